// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// Operations are latched at launch and retire a fixed number of cycles later;
// HI/LO can also be written directly (mthi/mtlo) and read through MDM_out.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        MDCCtrl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [1:0]        MDM_WE,
  input  logic [1:0]        MDM_RE,
  input  logic              req,
  output logic              busy,
  output logic [DATA_W-1:0] MDM_out
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONE = {DATA_W{1'b1}};

  // Signed divide returning {remainder, quotient}. The single overflowing case
  // (most negative / -1) is pinned to quotient = dividend, remainder = 0, and a
  // zero divisor yields zero so no X ever leaves this function.
  function automatic logic [2*DATA_W-1:0] div_signed(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if (a == INT_MIN && b == ALL_ONE) begin
      q = $signed(a);
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}; zero divisor yields zero.
  function automatic logic [2*DATA_W-1:0] div_unsigned(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [3:0]        cnt_q;

  // Operands and opcode captured at launch (data only, never reset)
  logic [2:0]        op_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;

  logic        op_valid;
  logic        launch;
  logic        mt_write;
  logic        retire;
  logic [3:0]  load_cnt;

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic        [2*DATA_W-1:0] div_s;
  logic        [2*DATA_W-1:0] div_u;
  logic        [2*DATA_W-1:0] res_p1;
  logic                       res_we_p1;

  assign busy = (cnt_q != 4'd0);

  // Launch and direct-write qualification; start outranks MDM_WE in the same cycle.
  always_comb begin
    op_valid = 1'b0;
    load_cnt = 4'd0;
    case (MDCCtrl)
      OP_MULT, OP_MULTU, OP_MADD: begin op_valid = 1'b1; load_cnt = MUL_CYCLES; end
      OP_DIV, OP_DIVU:            begin op_valid = 1'b1; load_cnt = DIV_CYCLES; end
      default:                    begin op_valid = 1'b0; load_cnt = 4'd0;       end
    endcase
  end

  assign launch   = start && !req && !busy && op_valid;
  assign mt_write = !start && !req && !busy;
  assign retire   = (cnt_q == 4'd1);

  // Capture operands when an operation is accepted
  always_ff @(posedge clk) begin
    if (launch) begin
      op_p0 <= MDCCtrl;
      a_p0  <= A;
      b_p0  <= B;
    end
  end

  // ---- Stage p0 -> p1: result formed from latched operands and current HI/LO ----
  assign prod_s = $signed({{DATA_W{a_p0[DATA_W-1]}}, a_p0}) *
                  $signed({{DATA_W{b_p0[DATA_W-1]}}, b_p0});
  assign prod_u = {{DATA_W{1'b0}}, a_p0} * {{DATA_W{1'b0}}, b_p0};
  assign div_s  = div_signed(a_p0, b_p0);
  assign div_u  = div_unsigned(a_p0, b_p0);

  // Select the retiring result; a zero divisor suppresses the HI/LO update.
  always_comb begin
    res_p1    = {hi_q, lo_q};
    res_we_p1 = 1'b0;
    case (op_p0)
      OP_MULT:  begin res_p1 = prod_s;                           res_we_p1 = 1'b1; end
      OP_MULTU: begin res_p1 = prod_u;                           res_we_p1 = 1'b1; end
      OP_MADD:  begin res_p1 = {hi_q, lo_q} + $unsigned(prod_s); res_we_p1 = 1'b1; end
      OP_DIV:   begin res_p1 = div_s;  res_we_p1 = (b_p0 != '0); end
      OP_DIVU:  begin res_p1 = div_u;  res_we_p1 = (b_p0 != '0); end
      default:  begin res_p1 = {hi_q, lo_q}; res_we_p1 = 1'b0; end
    endcase
  end

  // Cycle counter: load on launch, count down to zero while an op is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (launch) begin
      cnt_q <= load_cnt;
    end else if (busy) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // ---- Stage p1 -> architectural HI/LO: retire result or accept mthi/mtlo ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (retire) begin
      if (res_we_p1) begin
        hi_q <= res_p1[2*DATA_W-1:DATA_W];
        lo_q <= res_p1[DATA_W-1:0];
      end
    end else if (mt_write) begin
      if (MDM_WE == 2'b01) hi_q <= A;
      if (MDM_WE == 2'b10) lo_q <= A;
    end
  end

  // Read port: combinational view of HI/LO
  always_comb begin
    case (MDM_RE)
      2'b01:   MDM_out = hi_q;
      2'b10:   MDM_out = lo_q;
      default: MDM_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDCCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  MDM_WE;
  logic [1:0]  MDM_RE;
  logic        req;
  logic        busy;
  logic [31:0] MDM_out;

  int n_cmp;
  int n_bad;
  int n;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDCCtrl (MDCCtrl),
    .A       (A),
    .B       (B),
    .MDM_WE  (MDM_WE),
    .MDM_RE  (MDM_RE),
    .req     (req),
    .busy    (busy),
    .MDM_out (MDM_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    MDM_RE = sel;
    #1;
    chk(tag, MDM_out, exp);
  endtask

  task automatic mt(input logic [1:0] we, input logic [31:0] val);
    @(negedge clk);
    MDM_WE = we;
    A      = val;
    @(negedge clk);
    MDM_WE = 2'b00;
  endtask

  // Count negedge samples with busy high, bounded so a stuck busy still ends.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy);
    int c;
    @(negedge clk);
    start   = 1'b1;
    MDCCtrl = op;
    A       = a;
    B       = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    chk(tag, c, exp_busy);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; start = 1'b0; MDCCtrl = 3'b000; A = '0; B = '0;
    MDM_WE = 2'b00; MDM_RE = 2'b00; req = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rd_chk("rst_hi", 2'b01, 32'h0);
    rd_chk("rst_lo", 2'b10, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // mult -2 * 3
    run_op("mult_busy", 3'b000, 32'hFFFF_FFFE, 32'd3, 5);
    rd_chk("mult_hi", 2'b01, 32'hFFFF_FFFF);
    rd_chk("mult_lo", 2'b10, 32'hFFFF_FFFA);
    rd_chk("re_zero", 2'b00, 32'h0);

    // multu 0xFFFFFFFF * 2
    run_op("multu_busy", 3'b001, 32'hFFFF_FFFF, 32'd2, 5);
    rd_chk("multu_hi", 2'b01, 32'h0000_0001);
    rd_chk("multu_lo", 2'b10, 32'hFFFF_FFFE);

    // divu 7 / 2
    run_op("divu_busy", 3'b011, 32'd7, 32'd2, 10);
    rd_chk("divu_hi", 2'b01, 32'd1);
    rd_chk("divu_lo", 2'b10, 32'd3);

    // div -7 / 2
    run_op("div_busy", 3'b010, 32'hFFFF_FFF9, 32'd2, 10);
    rd_chk("div_hi", 2'b01, 32'hFFFF_FFFF);
    rd_chk("div_lo", 2'b10, 32'hFFFF_FFFD);

    // div overflow: INT_MIN / -1
    run_op("divovf_busy", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    rd_chk("divovf_hi", 2'b01, 32'h0);
    rd_chk("divovf_lo", 2'b10, 32'h8000_0000);

    // divide by zero leaves preset HI/LO
    mt(2'b01, 32'h11);
    mt(2'b10, 32'h22);
    rd_chk("mthi", 2'b01, 32'h11);
    rd_chk("mtlo", 2'b10, 32'h22);
    run_op("div0_busy", 3'b011, 32'd5, 32'd0, 10);
    rd_chk("div0_hi", 2'b01, 32'h11);
    rd_chk("div0_lo", 2'b10, 32'h22);

    // madd accumulates with carry into HI
    mt(2'b01, 32'h0);
    mt(2'b10, 32'hFFFF_FFFF);
    run_op("madd_busy", 3'b100, 32'd1, 32'd1, 5);
    rd_chk("madd_hi", 2'b01, 32'd1);
    rd_chk("madd_lo", 2'b10, 32'd0);

    // start and mtlo while busy are ignored; read shows pre-completion LO
    mt(2'b01, 32'h5);
    mt(2'b10, 32'h6);
    @(negedge clk);
    start = 1'b1; MDCCtrl = 3'b000; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b1; MDCCtrl = 3'b011; A = 32'hDEAD; B = 32'd1; MDM_WE = 2'b10;
    @(negedge clk);
    start = 1'b0; MDM_WE = 2'b00;
    rd_chk("busy_lo_hold", 2'b10, 32'h6);
    wait_done(n);
    chk("hazard_busy", n, 4);
    rd_chk("hazard_hi", 2'b01, 32'h0);
    rd_chk("hazard_lo", 2'b10, 32'd12);

    // start with req=1 is ignored, as is the concurrent write
    @(negedge clk);
    start = 1'b1; req = 1'b1; MDCCtrl = 3'b000; A = 32'h77; B = 32'd2; MDM_WE = 2'b01;
    @(negedge clk);
    start = 1'b0; req = 1'b0; MDM_WE = 2'b00;
    chk("req_busy", {31'b0, busy}, 32'd0);
    rd_chk("req_hi", 2'b01, 32'h0);

    // invalid opcode start is a no-op
    @(negedge clk);
    start = 1'b1; MDCCtrl = 3'b101; A = 32'd3; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("inv_busy", {31'b0, busy}, 32'd0);

    // start outranks MDM_WE in the same cycle
    mt(2'b01, 32'h33);
    @(negedge clk);
    start = 1'b1; MDCCtrl = 3'b000; A = 32'd9; B = 32'd0; MDM_WE = 2'b01;
    @(negedge clk);
    start = 1'b0; MDM_WE = 2'b00;
    rd_chk("prio_hi_busy", 2'b01, 32'h33);
    wait_done(n);
    chk("prio_busy", n, 5);
    rd_chk("prio_hi", 2'b01, 32'h0);

    // async reset at counter=3 aborts without a later write
    mt(2'b01, 32'h44);
    mt(2'b10, 32'h55);
    @(negedge clk);
    start = 1'b1; MDCCtrl = 3'b000; A = 32'd2; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    rd_chk("rstmid_hi", 2'b01, 32'h0);
    rd_chk("rstmid_lo", 2'b10, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstpost_busy", {31'b0, busy}, 32'd0);
    rd_chk("rstpost_hi", 2'b01, 32'h0);
    rd_chk("rstpost_lo", 2'b10, 32'h0);

    // start accepted on the first edge after reset release
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; MDCCtrl = 3'b011; A = 32'd7; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("rstrel_busy", n, 10);
    rd_chk("rstrel_hi", 2'b01, 32'd1);
    rd_chk("rstrel_lo", 2'b10, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: start  input  1  one-cycle pulse launching the operation selected by MDCCtrl.
REQ-004 SHALL have port: MDCCtrl  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd; other codes are no-ops.
REQ-005 SHALL have port: A  input  32  operand rs (dividend / multiplicand, also mthi/mtlo data).
REQ-006 SHALL have port: B  input  32  operand rt (divisor / multiplier).
REQ-007 SHALL have port: MDM_WE  input  2  01 write HI from A, 10 write LO from A, 00/11 no write.
REQ-008 SHALL have port: MDM_RE  input  2  01 select HI, 10 select LO, 00/11 select zero.
REQ-009 SHALL have port: req  input  1  exception/interrupt flush; when high, start and MDM_WE in that cycle are ignored.
REQ-010 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-011 SHALL have port: MDM_out  output  32  read data per MDM_RE, combinational from current HI/LO.

Function
REQ-012 SHALL hold internal 32-bit HI and LO registers plus a 4-bit cycle counter and latched operands/opcode.
REQ-013 SHALL, on rising edge with start=1, req=0, busy=0 and a valid MDCCtrl, latch A, B and MDCCtrl and load counter with 5 (mult/multu/madd) or 10 (div/divu).
REQ-014 SHALL drive busy = (counter != 0); busy is not asserted in the start cycle itself, first high the cycle after.
REQ-015 SHALL decrement counter by 1 each cycle while nonzero; on the edge where counter goes 1->0, write results to HI/LO, and busy falls the same edge.
REQ-016 SHALL compute mult as {HI,LO} = signed(A)*signed(B), 64-bit.
REQ-017 SHALL compute multu as {HI,LO} = unsigned(A)*unsigned(B), 64-bit.
REQ-018 SHALL compute madd as {HI,LO} = {HI,LO} + signed(A)*signed(B), modulo 2^64, using HI/LO values at completion.
REQ-019 SHALL compute div as LO = quotient truncated toward zero, HI = remainder with sign of dividend (signed).
REQ-020 SHALL compute divu as LO = A/B, HI = A%B (unsigned).
REQ-021 SHALL, for div/divu with B=0, still run 10 cycles and leave HI and LO unchanged.
REQ-022 SHALL, for div with A=0x80000000, B=0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-023 SHALL ignore start while busy=1 (no relaunch, no counter reload).
REQ-024 SHALL ignore MDM_WE while busy=1; when busy=0 and req=0, MDM_WE=01 writes HI<=A and 10 writes LO<=A on the edge.
REQ-025 SHALL give start priority over MDM_WE when both are active in the same cycle (write suppressed).
REQ-026 SHALL return MDM_out = HI (01), LO (10) or 0 otherwise, reflecting pre-completion values while busy.
REQ-027 SHALL treat start with invalid MDCCtrl (101-111) as no-op: counter stays 0, busy stays 0.
REQ-028 SHALL not provide a cancel input; an in-flight operation always completes unless reset.

Reset
REQ-029 SHALL, while reset=1, force HI=0, LO=0, counter=0, busy=0, independent of clk.
REQ-030 SHALL, on reset mid-operation, abort without writing HI/LO; MDM_out reads 0 afterwards.
REQ-031 SHALL accept a new start on the first rising edge after reset deasserts.

Verification
REQ-032 SHALL verify mult: A=0xFFFFFFFE (-2), B=3, start -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 SHALL verify divu: A=7, B=2 -> busy 10 cycles, HI=1, LO=3; div A=-7, B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-034 SHALL verify divide-by-zero: HI=0x11, LO=0x22 preset via mthi/mtlo, divu B=0 -> 10 busy cycles, HI=0x11, LO=0x22.
REQ-035 SHALL verify madd: HI=0, LO=0xFFFFFFFF, A=1, B=1 -> HI=1, LO=0 after 5 cycles.
REQ-036 SHALL verify hazards: start and MDM_WE=10 while busy ignored; start with req=1 -> busy stays 0.
REQ-037 SHALL verify reset at counter=3 of a mult -> busy=0, HI=LO=0 immediately, no later write.
